// File: rtl/arb_client_ctrl.sv
// arb_client_ctrl: per-client burst command front end for a shared arbiter.
// Each client latches a burst command, requests the arbiter, and issues one
// beat per granted cycle. Lock is held while further beats remain.
module arb_client_ctrl #(
  parameter int n           = 4,
  parameter int len_width   = 4,
  parameter int bit_width_n = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       init_n,
  input  logic                       enable,
  input  logic [n-1:0]               cmd_valid,
  output logic [n-1:0]               cmd_ready,
  input  logic [n*len_width-1:0]     cmd_len,
  input  logic [n*bit_width_n-1:0]   cmd_prior,
  output logic [n-1:0]               request,
  output logic [n*bit_width_n-1:0]   prior,
  output logic [n-1:0]               lock,
  input  logic [n-1:0]               grant,
  output logic                       beat_valid,
  output logic [bit_width_n-1:0]     beat_index,
  output logic                       beat_last,
  output logic                       grant_err
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } client_state_e;

  // True when more than one bit of the vector is set.
  function automatic logic multi_hot(input logic [n-1:0] v);
    return (v & (v - n'(1))) != '0;
  endfunction

  client_state_e                  state_q [n];
  client_state_e                  state_d [n];
  logic [len_width:0]             rem_q   [n];
  logic [len_width:0]             rem_d   [n];
  logic [n*bit_width_n-1:0]       prior_q;
  logic [n*bit_width_n-1:0]       prior_d;
  logic                           grant_err_q;
  logic                           grant_err_d;

  logic [bit_width_n-1:0]         beat_sel_s;
  logic                           beat_valid_s;
  logic                           beat_last_s;
  logic [n-1:0]                   active_s;
  logic [n-1:0]                   lock_s;

  // Flatten per-client state into an ACTIVE bit vector.
  always_comb begin
    active_s = '0;
    for (int i = 0; i < n; i++) begin
      active_s[i] = (state_q[i] == ST_ACTIVE);
    end
  end

  // Pick the lowest-index granted client; the beat fires only if it is ACTIVE.
  always_comb begin
    beat_sel_s = '0;
    for (int i = n - 1; i >= 0; i--) begin
      beat_sel_s = grant[i] ? bit_width_n'(i) : beat_sel_s;
    end
    beat_valid_s = enable & (|grant) & active_s[beat_sel_s];
    beat_last_s  = beat_valid_s & (rem_q[beat_sel_s] == (len_width+1)'(1));
  end

  // Lock keeps the arbiter on this client while more than one beat remains.
  always_comb begin
    lock_s = '0;
    for (int i = 0; i < n; i++) begin
      lock_s[i] = grant[i] & enable & active_s[i] & (rem_q[i] > (len_width+1)'(1));
    end
  end

  // Next-state: command accept, beat countdown, sticky grant error, init clear.
  always_comb begin
    prior_d     = prior_q;
    grant_err_d = grant_err_q;
    for (int i = 0; i < n; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
    end
    if (!init_n) begin
      prior_d     = '0;
      grant_err_d = 1'b0;
      for (int i = 0; i < n; i++) begin
        state_d[i] = ST_IDLE;
        rem_d[i]   = '0;
      end
    end else if (enable) begin
      grant_err_d = grant_err_q | multi_hot(grant);
      for (int i = 0; i < n; i++) begin
        case (state_q[i])
          ST_IDLE: begin
            if (cmd_valid[i]) begin
              state_d[i] = ST_ACTIVE;
              rem_d[i]   = {1'b0, cmd_len[i*len_width +: len_width]} + (len_width+1)'(1);
              prior_d[i*bit_width_n +: bit_width_n] = cmd_prior[i*bit_width_n +: bit_width_n];
            end else begin
              state_d[i] = ST_IDLE;
            end
          end
          ST_ACTIVE: begin
            if (beat_valid_s && (beat_sel_s == bit_width_n'(i))) begin
              rem_d[i] = rem_q[i] - (len_width+1)'(1);
              if (rem_q[i] == (len_width+1)'(1)) begin
                state_d[i] = ST_IDLE;
                prior_d[i*bit_width_n +: bit_width_n] = '0;
              end else begin
                state_d[i] = ST_ACTIVE;
              end
            end else begin
              state_d[i] = ST_ACTIVE;
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            rem_d[i]   = '0;
          end
        endcase
      end
    end else begin
      grant_err_d = grant_err_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prior_q     <= '0;
      grant_err_q <= 1'b0;
      for (int i = 0; i < n; i++) begin
        state_q[i] <= ST_IDLE;
        rem_q[i]   <= '0;
      end
    end else begin
      prior_q     <= prior_d;
      grant_err_q <= grant_err_d;
      for (int i = 0; i < n; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
      end
    end
  end

  assign cmd_ready  = ~active_s & {n{enable}};
  assign request    = active_s;
  assign prior      = prior_q;
  assign lock       = lock_s;
  assign beat_valid = beat_valid_s;
  assign beat_index = beat_valid_s ? beat_sel_s : '0;
  assign beat_last  = beat_last_s;
  assign grant_err  = grant_err_q;

endmodule

// File: tb/tb_arb_client_ctrl.sv
// Directed bench for arb_client_ctrl with hand-computed expectations.
module tb_arb_client_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_n;
  logic        enable;
  logic [3:0]  cmd_valid;
  logic [3:0]  cmd_ready;
  logic [15:0] cmd_len;
  logic [7:0]  cmd_prior;
  logic [3:0]  request;
  logic [7:0]  prior;
  logic [3:0]  lock;
  logic [3:0]  grant;
  logic        beat_valid;
  logic [1:0]  beat_index;
  logic        beat_last;
  logic        grant_err;

  int n_cmp = 0;
  int n_err = 0;

  arb_client_ctrl #(.n(4), .len_width(4), .bit_width_n(2)) dut (
    .clk(clk), .rst_n(rst_n), .init_n(init_n), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_prior(cmd_prior), .request(request), .prior(prior), .lock(lock),
    .grant(grant), .beat_valid(beat_valid), .beat_index(beat_index),
    .beat_last(beat_last), .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed and outputs
  // checked mid-cycle, well away from either edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic v, input logic [1:0] idx,
                          input logic last, input logic [3:0] lk);
    #1;
    check_eq({tag, "_valid"}, beat_valid, v);
    check_eq({tag, "_index"}, beat_index, idx);
    check_eq({tag, "_last"},  beat_last,  last);
    check_eq({tag, "_lock"},  lock,       lk);
  endtask

  initial begin
    rst_n = 1'b0; init_n = 1'b1; enable = 1'b1;
    cmd_valid = '0; cmd_len = '0; cmd_prior = '0; grant = '0;
    #2;
    // Reset state
    check_eq("rst_request", request, 4'h0);
    check_eq("rst_prior", prior, 8'h00);
    check_eq("rst_grant_err", grant_err, 1'b0);
    check_eq("rst_ready", cmd_ready, 4'hF);
    chk_beat("rst", 1'b0, 2'd0, 1'b0, 4'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Client 2, cmd_len=3 -> 4 beats
    cmd_valid = 4'b0100; cmd_len[8 +: 4] = 4'd3; cmd_prior[4 +: 2] = 2'd2;
    #1 check_eq("c2_ready", cmd_ready[2], 1'b1);
    tick();
    cmd_valid = '0;
    check_eq("c2_request", request, 4'b0100);
    check_eq("c2_prior", prior, 8'h20);
    grant = 4'b0100;
    for (int k = 1; k <= 4; k++) begin
      chk_beat("c2_beat", 1'b1, 2'd2, (k == 4), (k < 4) ? 4'b0100 : 4'b0000);
      check_eq("c2_busy_ready", cmd_ready[2], 1'b0);
      tick();
    end
    grant = '0;
    #1;
    check_eq("c2_done_request", request, 4'b0000);
    check_eq("c2_done_prior", prior, 8'h00);
    check_eq("c2_idle_ready", cmd_ready[2], 1'b1);
    tick();

    // Clients 0 (2 beats) and 1 (3 beats) commanded together
    cmd_valid = 4'b0011; cmd_len[0 +: 4] = 4'd1; cmd_len[4 +: 4] = 4'd2;
    cmd_prior[0 +: 2] = 2'd1; cmd_prior[2 +: 2] = 2'd3;
    tick();
    cmd_valid = '0;
    check_eq("c01_request", request, 4'b0011);
    check_eq("c01_prior", prior, 8'h0D);
    grant = 4'b0001;
    for (int k = 1; k <= 2; k++) begin
      chk_beat("c0_beat", 1'b1, 2'd0, (k == 2), (k < 2) ? 4'b0001 : 4'b0000);
      check_eq("c1_waiting", request[1], 1'b1);
      tick();
    end
    grant = 4'b0010;
    for (int k = 1; k <= 3; k++) begin
      chk_beat("c1_beat", 1'b1, 2'd1, (k == 3), (k < 3) ? 4'b0010 : 4'b0000);
      tick();
    end
    grant = '0;
    #1 check_eq("c01_done", request, 4'b0000);
    tick();

    // Enable drop mid-burst with rem=2
    cmd_valid = 4'b0010; cmd_len[4 +: 4] = 4'd3;
    tick();
    cmd_valid = '0;
    grant = 4'b0010;
    tick();
    tick();
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_beat("en0", 1'b0, 2'd0, 1'b0, 4'b0000);
      check_eq("en0_request", request, 4'b0010);
      check_eq("en0_ready", cmd_ready, 4'b0000);
      tick();
    end
    enable = 1'b1;
    chk_beat("resume1", 1'b1, 2'd1, 1'b0, 4'b0010);
    tick();
    chk_beat("resume2", 1'b1, 2'd1, 1'b1, 4'b0000);
    tick();
    grant = '0;
    #1 check_eq("resume_done", request, 4'b0000);

    // Parking grant on an idle client
    grant = 4'b1000;
    chk_beat("park", 1'b0, 2'd0, 1'b0, 4'b0000);
    tick();
    check_eq("park_err", grant_err, 1'b0);
    grant = '0;

    // Multi-hot grant
    cmd_valid = 4'b0011; cmd_len[0 +: 4] = 4'd1; cmd_len[4 +: 4] = 4'd1;
    tick();
    cmd_valid = '0;
    grant = 4'b0011;
    chk_beat("mh", 1'b1, 2'd0, 1'b0, 4'b0011);
    tick();
    check_eq("mh_err", grant_err, 1'b1);
    grant = 4'b0001;
    chk_beat("mh_c0_last", 1'b1, 2'd0, 1'b1, 4'b0000);
    tick();
    grant = 4'b0010;
    tick();
    tick();
    grant = '0;
    tick();
    check_eq("mh_err_sticky", grant_err, 1'b1);
    check_eq("mh_done", request, 4'b0000);
    init_n = 1'b0;
    tick();
    init_n = 1'b1;
    check_eq("init_clears_err", grant_err, 1'b0);

    // Async reset mid-burst of 16 beats, then a full 16-beat burst
    cmd_valid = 4'b1000; cmd_len[12 +: 4] = 4'd15; cmd_prior[6 +: 2] = 2'd2;
    tick();
    cmd_valid = '0;
    grant = 4'b1000;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("arst_request", request, 4'b0000);
    check_eq("arst_prior", prior, 8'h00);
    chk_beat("arst", 1'b0, 2'd0, 1'b0, 4'b0000);
    tick();
    rst_n = 1'b1;
    #1 check_eq("arst_ready", cmd_ready, 4'hF);
    cmd_valid = 4'b1000;
    tick();
    cmd_valid = '0;
    check_eq("max_prior", prior, 8'h80);
    for (int k = 1; k <= 16; k++) begin
      chk_beat("max_beat", 1'b1, 2'd3, (k == 16), (k < 16) ? 4'b1000 : 4'b0000);
      tick();
    end
    grant = '0;
    #1 check_eq("max_done", request, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arb_client_ctrl.md
ARB_CLIENT_CTRL -- requirements
Module: arb_client_ctrl

Interface
REQ-001 Parameter n, default 4, number of clients (2..16).
REQ-002 Parameter len_width, default 4, burst length field width; field value L means L+1 beats.
REQ-003 Parameter bit_width_n, default 2, equals ceil(log2(n)); width of priority and index fields.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 init_n  input  1  synchronous active-low init; clears state exactly as reset does.
REQ-007 enable  input  1  high: normal operation; low: state frozen.
REQ-008 cmd_valid  input  n  per-client burst command valid.
REQ-009 cmd_ready  output  n  per-client command accept.
REQ-010 cmd_len  input  n*len_width  per-client burst length (L+1 beats); client i in bits [i*len_width +: len_width].
REQ-011 cmd_prior  input  n*bit_width_n  per-client priority for the burst.
REQ-012 request  output  n  request to arbiter.
REQ-013 prior  output  n*bit_width_n  registered priority to arbiter.
REQ-014 lock  output  n  lock to arbiter.
REQ-015 grant  input  n  registered grant from arbiter.
REQ-016 beat_valid  output  1  a beat was issued this cycle.
REQ-017 beat_index  output  bit_width_n  client owning the beat.
REQ-018 beat_last  output  1  beat is the final beat of its burst.
REQ-019 grant_err  output  1  sticky flag: multi-hot grant seen.

Function
REQ-020 Each client i SHALL have a 2-state FSM, IDLE and ACTIVE, plus a len_width+1-bit remaining-beats counter rem[i] and a latched priority.
REQ-021 cmd_ready[i] SHALL be 1 exactly when client i is IDLE and enable is 1.
REQ-022 On cmd_valid[i] & cmd_ready[i]: next cycle ACTIVE, rem[i] = cmd_len[i]+1, prior field i = cmd_prior[i].
REQ-023 request[i] SHALL be 1 exactly when client i is ACTIVE (registered, no combinational path from cmd_valid).
REQ-024 prior field i SHALL hold the latched value while ACTIVE and SHALL be 0 while IDLE.
REQ-025 A beat for client i SHALL be issued in a cycle when enable=1, client i is ACTIVE, and i is the lowest-index asserted bit of grant.
REQ-026 On a beat: beat_valid=1, beat_index=i, beat_last=(rem[i]==1); rem[i] decrements; if rem[i]==1, client returns to IDLE next cycle.
REQ-027 lock[i] SHALL equal grant[i] & enable & ACTIVE & (rem[i]>1), combinationally, so the arbiter holds grant through the burst.
REQ-028 Grant to an IDLE client (arbiter parking) SHALL be ignored: no beat, no error.
REQ-029 ACTIVE client without grant SHALL keep request and rem unchanged (stall, no timeout).
REQ-030 More than one grant bit set in a cycle with enable=1 SHALL set grant_err next cycle; beat goes to lowest index per REQ-025.
REQ-031 enable=0: no command accepted, no beat issued, beat_valid=0, lock=0, FSM/rem/prior/request held.
REQ-032 A client finishing a burst SHALL not accept a new command in the same cycle; earliest new accept is the cycle after return to IDLE, earliest re-request two cycles after last beat.
REQ-033 Maximum burst cmd_len=2^len_width-1 SHALL yield 2^len_width beats without counter overflow.
REQ-034 beat_valid, beat_index, beat_last SHALL be combinational from state and grant (zero added latency).

Reset
REQ-035 rst_n=0 asynchronously, and init_n=0 at next clock edge, SHALL force: all clients IDLE, rem=0, request=0, prior=0, grant_err=0; hence lock=0, beat_valid=0, beat_index=0, beat_last=0.
REQ-036 Reset or init mid-burst SHALL abandon the burst with no further beats; cmd_ready resumes the first cycle after release with enable=1.

Verification
REQ-037 Client 2 cmd_len=3, grant[2] from cycle after request -> 4 beats on consecutive cycles, beat_index=2, lock[2]=1 on beats 1-3, 0 on beat 4, beat_last on beat 4 only.
REQ-038 Clients 0 and 1 commanded same cycle, grant 0 then 1 -> client 0 burst completes, then client 1 burst; request[1] stays 1 throughout client 0 burst.
REQ-039 Mid-burst (rem=2) drop enable 3 cycles -> no beats, lock=0, request held; resume delivers remaining 2 beats.
REQ-040 grant=4'b0011 with clients 0 and 1 ACTIVE -> beat_index=0, grant_err=1 next cycle and stays 1 until reset.
REQ-041 grant[3]=1 while client 3 IDLE -> beat_valid=0, grant_err=0.
REQ-042 Assert rst_n=0 mid-burst of cmd_len=15 -> all outputs zero immediately; after release, new cmd_len=15 yields 16 beats.
